// File: rtl/router_pkt_source.sv
// router_pkt_source: buffers one complete client packet, then streams header, payload
// and XOR parity to the router input port. Optional feature macro: ROUTER_SRC_ERR_INJ_EN.
module router_pkt_source #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_err,
  input  logic       pld_valid,
  output logic       pld_ready,
  input  logic [7:0] pld_data,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  input  logic       busy,
  output logic       tx_active,
  output logic       pkt_done,
`ifdef ROUTER_SRC_ERR_INJ_EN
  input  logic       inject_err,
`endif
  output logic [2:0] state_dbg
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are both 1
  // (router side: where busy is 0 while a byte is presented); valid never waits on ready.

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      len_q, len_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [7:0]      parity_q, parity_d;
  logic            inj_q, inj_d;
  logic [5:0]      wr_idx_q, wr_idx_d;
  logic [5:0]      rd_idx_q, rd_idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      data_q, data_d;
  logic            pv_q, pv_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [7:0]      mem [0:MAX_LEN-1];
  logic            inj_in;
  logic [6:0]      len_ext;
  logic            cmd_ok;

`ifdef ROUTER_SRC_ERR_INJ_EN
  assign inj_in = inject_err;
`else
  assign inj_in = 1'b0;
`endif

  // Length is range-checked against the buffer depth, not only the field width.
  assign len_ext = {1'b0, cmd_len};
  assign cmd_ok  = (cmd_len != 6'd0) && (cmd_addr != 2'd3) && (len_ext <= 7'(MAX_LEN));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hdr_d    = hdr_q;
    parity_d = parity_q;
    inj_d    = inj_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    gap_d    = gap_q;
    data_d   = data_q;
    pv_d     = pv_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else begin
            len_d    = cmd_len;
            hdr_d    = {cmd_len, cmd_addr};
            parity_d = {cmd_len, cmd_addr};
            inj_d    = inj_in;
            wr_idx_d = 6'd0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (pld_valid) begin
          parity_d = parity_q ^ pld_data;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == len_q - 6'd1) begin
            data_d   = hdr_q;
            pv_d     = 1'b1;
            rd_idx_d = 6'd0;
            state_d  = HEADER;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          data_d   = mem[6'd0];
          rd_idx_d = 6'd1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (rd_idx_q < len_q) begin
            data_d   = mem[rd_idx_q];
            rd_idx_d = rd_idx_q + 6'd1;
          end else begin
            data_d  = parity_q ^ {8{inj_q}};
            pv_d    = 1'b0;
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          done_d  = 1'b1;
          data_d  = 8'd0;
          gap_d   = GW'(GAP_CYCLES);
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) state_d = IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= 6'd0;
      hdr_q    <= 8'd0;
      parity_q <= 8'd0;
      inj_q    <= 1'b0;
      wr_idx_q <= 6'd0;
      rd_idx_q <= 6'd0;
      gap_q    <= '0;
      data_q   <= 8'd0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      hdr_q    <= hdr_d;
      parity_q <= parity_d;
      inj_q    <= inj_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Packet buffer keeps its contents across reset; only the indices are cleared.
  always_ff @(posedge clock) begin
    if (state_q == LOAD && pld_valid) mem[wr_idx_q] <= pld_data;
  end

  assign cmd_ready = (state_q == IDLE);
  assign pld_ready = (state_q == LOAD);
  assign tx_active = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == PARITY);
  assign data_out  = data_q;
  assign pkt_valid = pv_q;
  assign cmd_err   = err_q;
  assign pkt_done  = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// tb_router_pkt_source: directed scenarios for router_pkt_source with inline
// checks against hand-computed byte streams.
module tb_router_pkt_source;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_err;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] pld_data;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       busy;
  logic       tx_active;
  logic       pkt_done;
  logic [2:0] state_dbg;
`ifdef ROUTER_SRC_ERR_INJ_EN
  logic       inject_err;
`endif

  int checks = 0;
  int fails  = 0;

  router_pkt_source dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_err   (cmd_err),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .pld_data  (pld_data),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .tx_active (tx_active),
    .pkt_done  (pkt_done),
`ifdef ROUTER_SRC_ERR_INJ_EN
    .inject_err(inject_err),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_cmd(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] b [$]);
    foreach (b[i]) begin
      pld_valid = 1'b1;
      pld_data  = b[i];
      @(posedge clock); #1;
    end
    pld_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 6'd3;
    @(posedge clock); #1;
    checks++; if (data_out !== 8'h00)  begin fails++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if (pkt_valid !== 1'b0)  begin fails++; $display("FAIL rst_pkt_valid got=%b exp=0", pkt_valid); end
    checks++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (pld_ready !== 1'b0)  begin fails++; $display("FAIL rst_pld_ready got=%b exp=0", pld_ready); end
    checks++; if (cmd_err !== 1'b0)    begin fails++; $display("FAIL rst_cmd_err got=%b exp=0", cmd_err); end
    checks++; if (pkt_done !== 1'b0)   begin fails++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
    checks++; if (tx_active !== 1'b0)  begin fails++; $display("FAIL rst_tx_active got=%b exp=0", tx_active); end
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (pld_ready !== 1'b0)  begin fails++; $display("FAIL rst_cmd_ignored got=%b exp=0", pld_ready); end
    checks++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL rst_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] pl [$];
    logic [7:0] ed [5];
    logic       ev [5];
    pl = '{8'h11, 8'h22, 8'h33};
    ed = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_cmd(2'd1, 6'd3);
    checks++; if (pld_ready !== 1'b1) begin fails++; $display("FAIL basic_pld_ready got=%b exp=1", pld_ready); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL basic_cmd_ready got=%b exp=0", cmd_ready); end
    load_bytes(pl);
    checks++; if (tx_active !== 1'b1) begin fails++; $display("FAIL basic_tx_active got=%b exp=1", tx_active); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (data_out !== ed[k])  begin fails++; $display("FAIL basic_data[%0d] got=%h exp=%h", k, data_out, ed[k]); end
      checks++; if (pkt_valid !== ev[k]) begin fails++; $display("FAIL basic_valid[%0d] got=%b exp=%b", k, pkt_valid, ev[k]); end
      checks++; if (pkt_done !== 1'b0)   begin fails++; $display("FAIL basic_done_early[%0d] got=%b exp=0", k, pkt_done); end
      @(posedge clock); #1;
    end
    checks++; if (pkt_done !== 1'b1)  begin fails++; $display("FAIL basic_done got=%b exp=1", pkt_done); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL basic_data_idle got=%h exp=00", data_out); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL basic_gap1_ready got=%b exp=0", cmd_ready); end
    @(posedge clock); #1;
    checks++; if (pkt_done !== 1'b0)  begin fails++; $display("FAIL basic_done_once got=%b exp=0", pkt_done); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL basic_gap2_ready got=%b exp=0", cmd_ready); end
    @(posedge clock); #1;
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_busy();
    logic [7:0] pl [$];
    logic [7:0] ed [10];
    logic       ev [10];
    logic       bz [10];
    pl = '{8'h11, 8'h22, 8'h33};
    ed = '{8'h0D, 8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D, 8'h0D};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bz = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_cmd(2'd1, 6'd3);
    load_bytes(pl);
    for (int k = 0; k < 10; k++) begin
      checks++; if (data_out !== ed[k])  begin fails++; $display("FAIL busy_data[%0d] got=%h exp=%h", k, data_out, ed[k]); end
      checks++; if (pkt_valid !== ev[k]) begin fails++; $display("FAIL busy_valid[%0d] got=%b exp=%b", k, pkt_valid, ev[k]); end
      checks++; if (pkt_done !== 1'b0)   begin fails++; $display("FAIL busy_done_early[%0d] got=%b exp=0", k, pkt_done); end
      busy = bz[k];
      @(posedge clock); #1;
    end
    checks++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL busy_done got=%b exp=1", pkt_done); end
  endtask

  task automatic test_cmd_err();
    logic [1:0] ea [2];
    logic [5:0] el [2];
    ea = '{2'd1, 2'd3};
    el = '{6'd0, 6'd5};
    for (int c = 0; c < 2; c++) begin
      do_cmd(ea[c], el[c]);
      checks++; if (cmd_err !== 1'b1)   begin fails++; $display("FAIL err_pulse[%0d] got=%b exp=1", c, cmd_err); end
      checks++; if (pld_ready !== 1'b0) begin fails++; $display("FAIL err_pld_ready[%0d] got=%b exp=0", c, pld_ready); end
      checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL err_stay_idle[%0d] got=%b exp=1", c, cmd_ready); end
      @(posedge clock); #1;
      checks++; if (cmd_err !== 1'b0)   begin fails++; $display("FAIL err_once[%0d] got=%b exp=0", c, cmd_err); end
      checks++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL err_pkt_valid[%0d] got=%b exp=0", c, pkt_valid); end
      checks++; if (pld_ready !== 1'b0) begin fails++; $display("FAIL err_pld_ready2[%0d] got=%b exp=0", c, pld_ready); end
    end
  endtask

  task automatic test_max_len();
    logic [7:0] pl [$];
    logic [7:0] exp_d;
    for (int i = 0; i < 63; i++) pl.push_back(8'(i));
    do_cmd(2'd2, 6'd63);
    load_bytes(pl);
    for (int k = 0; k < 65; k++) begin
      exp_d = (k == 0) ? 8'hFE : ((k == 64) ? 8'hC1 : 8'(k - 1));
      checks++; if (data_out !== exp_d) begin fails++; $display("FAIL max_data[%0d] got=%h exp=%h", k, data_out, exp_d); end
      checks++; if (pkt_valid !== (k != 64)) begin fails++; $display("FAIL max_valid[%0d] got=%b exp=%b", k, pkt_valid, k != 64); end
      @(posedge clock); #1;
    end
    checks++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL max_done got=%b exp=1", pkt_done); end
  endtask

  task automatic test_load_gaps();
    logic [7:0] pl [4];
    logic [7:0] ed [6];
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ed = '{8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h14};
    do_cmd(2'd0, 6'd4);
    for (int i = 0; i < 10; i++) begin
      checks++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL gaps_early_valid[%0d] got=%b exp=0", i, pkt_valid); end
      checks++; if (pld_ready !== 1'b1) begin fails++; $display("FAIL gaps_pld_ready[%0d] got=%b exp=1", i, pld_ready); end
      pld_valid = (i % 3 == 0);
      pld_data  = (i % 3 == 0) ? pl[i / 3] : 8'hEE;
      @(posedge clock); #1;
    end
    pld_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (data_out !== ed[k]) begin fails++; $display("FAIL gaps_data[%0d] got=%h exp=%h", k, data_out, ed[k]); end
      checks++; if (pkt_valid !== (k != 5)) begin fails++; $display("FAIL gaps_valid[%0d] got=%b exp=%b", k, pkt_valid, k != 5); end
      @(posedge clock); #1;
    end
    checks++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL gaps_done got=%b exp=1", pkt_done); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl [$];
    logic [7:0] pl2 [$];
    logic [7:0] ed [6];
    logic [7:0] ed2 [4];
    pl  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pl2 = '{8'h5A, 8'hC3};
    ed  = '{8'h19, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ed2 = '{8'h0A, 8'h5A, 8'hC3, 8'h93};
    do_cmd(2'd1, 6'd6);
    load_bytes(pl);
    for (int k = 0; k < 6; k++) begin
      checks++; if (data_out !== ed[k]) begin fails++; $display("FAIL rmid_data[%0d] got=%h exp=%h", k, data_out, ed[k]); end
      if (k < 5) begin
        @(posedge clock); #1;
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_valid got=%b exp=0", pkt_valid); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL rmid_async_data got=%h exp=00", data_out); end
    checks++; if (tx_active !== 1'b0) begin fails++; $display("FAIL rmid_tx_active got=%b exp=0", tx_active); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (pkt_done !== 1'b0)  begin fails++; $display("FAIL rmid_no_done got=%b exp=0", pkt_done); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_idle got=%b exp=1", cmd_ready); end
    do_cmd(2'd2, 6'd2);
    load_bytes(pl2);
    for (int k = 0; k < 4; k++) begin
      checks++; if (data_out !== ed2[k]) begin fails++; $display("FAIL rmid2_data[%0d] got=%h exp=%h", k, data_out, ed2[k]); end
      checks++; if (pkt_valid !== (k != 3)) begin fails++; $display("FAIL rmid2_valid[%0d] got=%b exp=%b", k, pkt_valid, k != 3); end
      @(posedge clock); #1;
    end
    checks++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL rmid2_done got=%b exp=1", pkt_done); end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd0;
    pld_valid = 1'b0;
    pld_data  = 8'h00;
    busy      = 1'b0;
`ifdef ROUTER_SRC_ERR_INJ_EN
    inject_err = 1'b0;
`endif
    test_reset();
    test_basic();
    test_busy();
    test_cmd_err();
    test_max_len();
    test_load_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
